// File: rtl/grover_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grover_pkg
// Description : Shared constants and types for the Grover search datapath.
//               The oracle, diffusion and measurement blocks all use these.
// Contents    : NUM_BIT    - basis-state index width
//               NUM_SAMPLE - amplitudes per frame (2**NUM_BIT)
//               AMP_W      - signed amplitude width
//               meas_state_t - measurement FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package grover_pkg;

    localparam int NUM_BIT    = 3;
    localparam int NUM_SAMPLE = 2 ** NUM_BIT;
    localparam int AMP_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } meas_state_t;

endpackage : grover_pkg
`default_nettype wire

// File: rtl/amp_mag_cmp.sv
`default_nettype none
// ============================================================================
// Module      : amp_mag_cmp
// Description : Combinational magnitude comparator for two signed amplitudes.
//               Flags when |cand| is strictly greater than |best|.
// Ports       : cand  (in)  AMP_W  signed candidate amplitude
//               best  (in)  AMP_W  signed stored best amplitude
//               gt    (out) 1      |cand| > |best|
// Revision    : 1.0 - initial release
// ============================================================================
module amp_mag_cmp #(
    parameter int AMP_W = 8
) (
    input  logic [AMP_W-1:0] cand,
    input  logic [AMP_W-1:0] best,
    output logic             gt
);

    logic [AMP_W-1:0] w_cand_mag;
    logic [AMP_W-1:0] w_best_mag;

    // Two's-complement negate kept at AMP_W bits and read as unsigned:
    // the most negative value maps to 2**(AMP_W-1) with no saturation.
    always_comb begin
        w_cand_mag = cand[AMP_W-1] ? (~cand + 1'b1) : cand;
        w_best_mag = best[AMP_W-1] ? (~best + 1'b1) : best;
        gt         = (w_cand_mag > w_best_mag);
    end

endmodule : amp_mag_cmp
`default_nettype wire

// File: rtl/grover_measure.sv
`default_nettype none
// ============================================================================
// Module      : grover_measure
// Description : Measurement/decode stage. Collects one frame of NUM_SAMPLE
//               signed amplitudes over valid/ready, tracks the sample with
//               the largest magnitude (ties keep the lowest index) and
//               reports its index, amplitude, squared magnitude and sign.
// Ports       : clk       (in)  clock, rising edge
//               rst_n     (in)  asynchronous active-low reset
//               start     (in)  begin a new frame
//               in_valid  (in)  in_amp carries a sample
//               in_ready  (out) sample accepted this cycle
//               in_amp    (in)  AMP_W signed amplitude, index order
//               busy      (out) COLLECT or DONE
//               out_valid (out) result valid and held
//               out_ready (in)  consumer takes the result
//               out_index (out) NUM_BIT index of max-magnitude sample
//               out_amp   (out) AMP_W signed amplitude at out_index
//               out_prob  (out) 2*AMP_W unsigned out_amp squared
//               out_neg   (out) out_amp is negative (marked phase)
// Revision    : 1.0 - initial release
// ============================================================================
module grover_measure #(
    parameter int NUM_BIT    = 3,
    parameter int NUM_SAMPLE = 2 ** NUM_BIT,
    parameter int AMP_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AMP_W-1:0]     in_amp,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_BIT-1:0]   out_index,
    output logic [AMP_W-1:0]     out_amp,
    output logic [2*AMP_W-1:0]   out_prob,
    output logic                 out_neg
);

    import grover_pkg::*;

    localparam logic [NUM_BIT-1:0] LAST_CNT = NUM_BIT'(NUM_SAMPLE - 1);
    localparam logic [NUM_BIT-1:0] CNT_ONE  = NUM_BIT'(1);

    meas_state_t r_state;
    meas_state_t w_state_nxt;

    logic [NUM_BIT-1:0]   r_cnt;
    logic [NUM_BIT-1:0]   r_best_idx;
    logic [AMP_W-1:0]     r_best_amp;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_clear;
    logic                 w_gt;
    logic                 w_take;
    logic [NUM_BIT-1:0]   w_new_idx;
    logic [AMP_W-1:0]     w_new_amp;
    logic [2*AMP_W-1:0]   w_amp_ext;
    logic [2*AMP_W-1:0]   w_prod;

    amp_mag_cmp #(
        .AMP_W (AMP_W)
    ) u_amp_mag_cmp (
        .cand (in_amp),
        .best (r_best_amp),
        .gt   (w_gt)
    );

    // ------------------------------------------------------------------
    // Datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept  = (r_state == COLLECT) && in_valid;
        w_last    = (r_cnt == LAST_CNT);
        // A new frame starts from IDLE, or straight out of DONE when the
        // consumer takes the result in the same cycle start is raised.
        w_clear   = start && ((r_state == IDLE) ||
                              ((r_state == DONE) && out_ready));
        // Sample 0 seeds the search regardless of the stale best register.
        w_take    = (r_cnt == '0) || w_gt;
        w_new_idx = w_take ? r_cnt  : r_best_idx;
        w_new_amp = w_take ? in_amp : r_best_amp;
        // Sign-extend then square; the low 2*AMP_W bits of the product are
        // the exact square, including (-2**(AMP_W-1))**2.
        w_amp_ext = {{AMP_W{w_new_amp[AMP_W-1]}}, w_new_amp};
        w_prod    = w_amp_ext * w_amp_ext;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (w_accept && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = start ? COLLECT : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter and running best
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_best_idx <= '0;
            r_best_amp <= '0;
        end else if (w_clear) begin
            r_cnt      <= '0;
            r_best_idx <= '0;
            r_best_amp <= '0;
        end else if (w_accept) begin
            r_cnt      <= w_last ? '0 : (r_cnt + CNT_ONE);
            r_best_idx <= w_new_idx;
            r_best_amp <= w_new_amp;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded only on the COLLECT->DONE transition so
    // the previous frame's result stays visible until the next one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_index <= '0;
            out_amp   <= '0;
            out_prob  <= '0;
            out_neg   <= 1'b0;
        end else if (w_accept && w_last) begin
            out_index <= w_new_idx;
            out_amp   <= w_new_amp;
            out_prob  <= w_prod;
            out_neg   <= w_new_amp[AMP_W-1];
        end
    end

endmodule : grover_measure
`default_nettype wire

// File: doc/grover_measure.md
# grover_measure

Sequential measurement and decode stage for the Grover search datapath. It receives the 8-entry signed amplitude vector one sample per cycle over a valid/ready handshake. It locates the basis state with the largest magnitude and reports that state's index, signed amplitude, squared-magnitude probability and phase sign. The block sits after the phase-inversion/diffusion chain and recovers the target index that the oracle encoded into the phase.

## Interface
- Clock is `clk`; reset is `rst_n`, asynchronous and active-low.
- Parameters:
  - `NUM_BIT`, default 3: index width.
  - `NUM_SAMPLE`, default 2**NUM_BIT: amplitudes per frame.
  - `AMP_W`, default 8: signed amplitude width.
- Ports:
  - `clk`  input  1  rising-edge clock.
  - `rst_n`  input  1  asynchronous active-low reset.
  - `start`  input  1  begin a new frame.
  - `in_valid`  input  1  `in_amp` holds a valid sample.
  - `in_ready`  output  1  block accepts a sample this cycle.
  - `in_amp`  input  AMP_W  signed amplitude. Samples arrive in index order 0..NUM_SAMPLE-1.
  - `busy`  output  1  high in COLLECT and DONE.
  - `out_valid`  output  1  result valid and held.
  - `out_ready`  input  1  consumer takes the result.
  - `out_index`  output  NUM_BIT  index of the maximum-magnitude sample.
  - `out_amp`  output  AMP_W  signed amplitude at `out_index`.
  - `out_prob`  output  2*AMP_W  unsigned `out_amp`².
  - `out_neg`  output  1  `out_amp` < 0 (marked phase).

## Operation
- FSM states are IDLE, COLLECT and DONE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 → COLLECT. Sample counter, best index and best amplitude are cleared.
- COLLECT:
  - `in_ready`=1.
  - Each cycle with `in_valid`&&`in_ready` accepts `in_amp` as sample number `cnt`.
  - The accepted sample's magnitude is compared with the stored best magnitude. It replaces the best only if strictly greater, so ties resolve to the lowest index.
  - Sample 0 always loads as the best.
  - Acceptance of sample NUM_SAMPLE-1 → DONE.
  - `start` is ignored in COLLECT.
  - `in_valid` low stalls the frame indefinitely with no timeout.
- DONE:
  - `in_ready`=0, `out_valid`=1.
  - Outputs hold stable until `out_ready`=1.
  - `out_ready`=1 with `start`=0 → IDLE.
  - `out_ready`=1 with `start`=1 → COLLECT directly, with state cleared, to allow back-to-back frames.
  - `start` without `out_ready` is ignored.
- Arithmetic:
  - Magnitude is |a| as an AMP_W-bit unsigned value. -2^(AMP_W-1) maps to 2^(AMP_W-1), with no saturation, so -128 has magnitude 128.
  - `out_prob` = `out_amp`×`out_amp` as a full-width signed multiply, taken as 2*AMP_W unsigned. (-128)² = 16384.
  - `out_prob` is registered when entering DONE.
  - `out_neg` = MSB of `out_amp`.
- Result outputs (`out_index`, `out_amp`, `out_prob`, `out_neg`):
  - They change only on the COLLECT→DONE transition.
  - They are otherwise held, including in IDLE.
  - They hold the last frame until the next DONE.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `out_valid`=0, `out_index`=0, `out_amp`=0, `out_prob`=0, `out_neg`=0, state IDLE, counter 0.
- Reset asserted mid-frame aborts immediately, and the partial frame is discarded.
- `in_ready` rises the cycle after `start` is sampled.
- `out_valid` rises the cycle after the NUM_SAMPLE-th accepted sample.
- Minimum frame with no stalls is 1 (start) + NUM_SAMPLE (samples) + 1 (DONE handshake) cycles, i.e. 10 for the defaults.
- All outputs are registered. There is no combinational path from `in_*` to `out_*`, and none from `out_ready` to `in_ready`.

## Structure
- Shared package `grover_pkg` holds:
  - `NUM_BIT`, `AMP_W`, `NUM_SAMPLE`;
  - the state typedef `meas_state_t` {IDLE, COLLECT, DONE}.
  - These are shared with the oracle and diffusion blocks.
- One sub-module, `amp_mag_cmp`: combinational |a| for the candidate and stored best, plus a strictly-greater flag.
- The FSM, counter and result registers live in `grover_measure`.

## Test plan
- Marked frame: start, amplitudes {11,11,11,11,11,-80,11,11} → `out_index`=5, `out_amp`=-80, `out_prob`=6400, `out_neg`=1, one cycle after the 8th sample.
- Tie resolution:
  - {20,-20,20,20,20,20,20,20} → `out_index`=0, `out_amp`=20, `out_neg`=0.
  - {0,0,-30,30,0,0,0,0} → index 2.
- Extreme value: index 7 = -128, others 127 → `out_index`=7, `out_prob`=16384, `out_neg`=1.
- Handshake stress:
  - Random `in_valid` gaps → result unchanged versus the no-gap run.
  - `out_ready` held low 5 cycles → outputs stable, `in_ready`=0.
  - `start` during COLLECT is ignored.
- Back-to-back frames: `out_ready`=1 and `start`=1 in DONE → the second frame is collected with no idle cycle, and both results are correct.
- Reset mid-frame: `rst_n` low after 4 samples → all outputs 0, state IDLE. A new full frame then produces the correct result.
